// File: rtl/system_pkg.sv
// Shared SoC bus constants: widths, AHB-Lite transfer encodings and the byte-strobe helper.
package system_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Byte lanes touched by an AHB beat on a 32-bit bus; unsupported sizes give no lanes.
  function automatic logic [3:0] ahbl_strb(input logic [2:0] hsize, input logic [1:0] addr);
    case (hsize)
      HSIZE_BYTE: return 4'b0001 << addr;
      HSIZE_HALF: return 4'b0011 << addr;
      HSIZE_WORD: return 4'b1111;
      default:    return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/ahbl2apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP+ACCESS per accepted AHB beat,
// AHB data phase stretched until the APB access completes, PSLVERR mapped to AHB ERROR.
module ahbl2apb_bridge #(
  parameter int ADDR_WIDTH     = system_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH     = system_pkg::DATA_WIDTH,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ahbl_hsel,
  input  logic [ADDR_WIDTH-1:0]     ahbl_haddr,
  input  logic [1:0]                ahbl_htrans,
  input  logic                      ahbl_hwrite,
  input  logic [2:0]                ahbl_hsize,
  input  logic [DATA_WIDTH-1:0]     ahbl_hwdata,
  input  logic                      ahbl_hready,
  output logic                      ahbl_hreadyout,
  output logic [DATA_WIDTH-1:0]     ahbl_hrdata,
  output logic                      ahbl_hresp,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr,
  output logic                      apb_psel,
  output logic                      apb_penable,
  output logic                      apb_pwrite,
  output logic [DATA_WIDTH-1:0]     apb_pwdata,
  output logic [3:0]                apb_pstrb,
  input  logic [DATA_WIDTH-1:0]     apb_prdata,
  input  logic                      apb_pready,
  input  logic                      apb_pslverr
);
  import system_pkg::*;

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2} state_t;

  state_t state, state_next;
  logic   accept, decode_err, apb_done;

  logic unused_bits;
  assign unused_bits = ^{ahbl_haddr[ADDR_WIDTH-1:APB_ADDR_WIDTH], ahbl_htrans[0]};

  always_comb begin
    accept     = ahbl_hsel && ahbl_hready && ahbl_htrans[1];
    decode_err = (ahbl_hsize > HSIZE_WORD)
              || (ahbl_hsize == HSIZE_HALF && ahbl_haddr[0])
              || (ahbl_hsize == HSIZE_WORD && ahbl_haddr[1:0] != 2'b00);
    // pready only counts once the ACCESS phase is actually visible on the APB bus
    apb_done   = apb_penable && apb_pready;

    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (decode_err)       state_next = S_ERR1;
          else if (ahbl_hwrite) state_next = S_WDATA;
          else                  state_next = S_SETUP;
        end
      end
      S_WDATA:  state_next = S_SETUP;
      S_SETUP:  state_next = S_ACCESS;
      S_ACCESS: if (apb_done) state_next = apb_pslverr ? S_ERR1 : S_IDLE;
      S_ERR1:   state_next = S_ERR2;
      S_ERR2:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // APB strobes are registered from the current state, so the bus shows SETUP one
  // cycle after the FSM enters it; AHB handshake outputs follow the next state directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ahbl_hreadyout <= 1'b1;
      ahbl_hresp     <= 1'b0;
      ahbl_hrdata    <= '0;
      apb_psel       <= 1'b0;
      apb_penable    <= 1'b0;
      apb_pwrite     <= 1'b0;
      apb_paddr      <= '0;
      apb_pwdata     <= '0;
      apb_pstrb      <= '0;
    end else begin
      ahbl_hreadyout <= (state_next == S_IDLE) || (state_next == S_ERR2);
      ahbl_hresp     <= (state_next == S_ERR1) || (state_next == S_ERR2);
      apb_psel       <= (state == S_SETUP) || (state == S_ACCESS && !apb_done);
      apb_penable    <= (state == S_ACCESS) && !apb_done;

      if (state == S_IDLE && accept && !decode_err) begin
        apb_paddr  <= ahbl_haddr[APB_ADDR_WIDTH-1:0];
        apb_pwrite <= ahbl_hwrite;
        apb_pstrb  <= ahbl_hwrite ? ahbl_strb(ahbl_hsize, ahbl_haddr[1:0]) : 4'b0000;
      end
      if (state == S_WDATA)
        apb_pwdata <= ahbl_hwdata;
      if (state == S_ACCESS && apb_done && !apb_pwrite && !apb_pslverr)
        ahbl_hrdata <= apb_prdata;
    end
  end

endmodule

// File: tb/tb_ahbl2apb_bridge.sv
// Directed and randomized bench for ahbl2apb_bridge with a behavioural APB slave and
// an expectation model derived from transfer size/address/direction arithmetic.
module tb_ahbl2apb_bridge;
  import system_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hwrite, hready, hreadyout, hresp;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [11:0] paddr;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] pwdata, prdata;
  logic [3:0]  pstrb;

  int          cfg_wait;
  logic        cfg_err;
  logic [31:0] cfg_rdata;

  int checks   = 0;
  int failures = 0;

  ahbl2apb_bridge dut (
    .clk(clk), .rst(rst),
    .ahbl_hsel(hsel), .ahbl_haddr(haddr), .ahbl_htrans(htrans), .ahbl_hwrite(hwrite),
    .ahbl_hsize(hsize), .ahbl_hwdata(hwdata), .ahbl_hready(hready),
    .ahbl_hreadyout(hreadyout), .ahbl_hrdata(hrdata), .ahbl_hresp(hresp),
    .apb_paddr(paddr), .apb_psel(psel), .apb_penable(penable), .apb_pwrite(pwrite),
    .apb_pwdata(pwdata), .apb_pstrb(pstrb), .apb_prdata(prdata), .apb_pready(pready),
    .apb_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Single-slave fabric: the bus HREADY is this slave's HREADYOUT.
  assign hready = hreadyout;

  // APB slave: inserts cfg_wait ACCESS wait cycles, records SETUP and ACCESS snapshots.
  int          acc_cnt;
  int          apb_xfers, pen_cycles, psel_cycles;
  logic [11:0] setup_paddr, acc_paddr;
  logic [31:0] setup_pwdata, acc_pwdata;
  logic [3:0]  setup_pstrb, acc_pstrb;
  logic        setup_pwrite;

  assign pready  = penable && (acc_cnt >= cfg_wait);
  assign pslverr = pready && cfg_err;
  assign prdata  = cfg_rdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt <= 0;
    end else begin
      acc_cnt <= (penable && !pready) ? acc_cnt + 1 : 0;
    end
  end

  initial begin
    apb_xfers = 0; pen_cycles = 0; psel_cycles = 0;
    setup_paddr = '0; acc_paddr = '0; setup_pwdata = '0; acc_pwdata = '0;
    setup_pstrb = '0; acc_pstrb = '0; setup_pwrite = 1'b0;
  end

  always @(posedge clk) begin
    if (psel) psel_cycles <= psel_cycles + 1;
    if (penable) pen_cycles <= pen_cycles + 1;
    if (psel && !penable) begin
      setup_paddr  <= paddr;
      setup_pwdata <= pwdata;
      setup_pstrb  <= pstrb;
      setup_pwrite <= pwrite;
    end
    if (psel && penable && pready) begin
      acc_paddr  <= paddr;
      acc_pwdata <= pwdata;
      acc_pstrb  <= pstrb;
      apb_xfers  <= apb_xfers + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: lanes = (2^(2^size) - 1) shifted to the byte offset; reads carry no lanes.
  function automatic logic [3:0] model_strb(input logic w, input logic [2:0] sz, input logic [31:0] a);
    int lanes;
    lanes = ((1 << (1 << sz)) - 1) << a[1:0];
    return w ? lanes[3:0] : 4'b0000;
  endfunction

  // One AHB beat: address phase, then data phase until HREADYOUT; returns wait-state count.
  task automatic ahb_xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                          input logic [1:0] tr, input logic [31:0] wd,
                          output int waits, output logic last_wait_resp,
                          output logic final_resp, output logic [31:0] rd);
    hsel = 1'b1; haddr = a; htrans = tr; hwrite = w; hsize = sz; hwdata = '0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; haddr = '0; hwdata = wd;
    waits = 0; last_wait_resp = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (hreadyout) break;
      waits++;
      last_wait_resp = hresp;
    end
    check("xfer_completes", {31'd0, hreadyout}, 32'd1);
    final_resp = hresp;
    rd = hrdata;
    @(posedge clk); #1;
  endtask

  int          waits, xf0, pc0, ps0;
  logic        lresp, fresp;
  logic [31:0] rd, a, wd;
  logic        w;
  logic [2:0]  sz;
  int          extra;

  initial begin
    rst = 1'b1; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    hsize = HSIZE_WORD; hwdata = '0; cfg_wait = 0; cfg_err = 1'b0; cfg_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    check("rst_hresp", {31'd0, hresp}, 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_psel_penable", {30'd0, psel, penable}, 32'd0);
    check("rst_pwrite_pstrb", {27'd0, pwrite, pstrb}, 32'd0);
    check("rst_paddr_pwdata", {20'd0, paddr} | pwdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: word read
    cfg_rdata = 32'hDEAD_BEEF;
    ahb_xfer(32'h4000_0010, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'd0, waits, lresp, fresp, rd);
    $display("T1 read waits=%0d hrdata=%h paddr=%h pstrb=%b", waits, rd, setup_paddr, setup_pstrb);
    check("t1_waits", waits, 3);
    check("t1_hrdata", rd, 32'hDEAD_BEEF);
    check("t1_hresp", {31'd0, fresp}, 32'd0);
    check("t1_paddr", {20'd0, setup_paddr}, 32'h010);
    check("t1_pstrb", {28'd0, setup_pstrb}, 32'd0);

    // 2: byte write to lane 3
    ahb_xfer(32'h4000_0003, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ, 32'hAB00_0000, waits, lresp, fresp, rd);
    $display("T2 write waits=%0d pstrb=%b pwdata=%h", waits, setup_pstrb, setup_pwdata);
    check("t2_waits", waits, 4);
    check("t2_pstrb", {28'd0, setup_pstrb}, 32'h8);
    check("t2_pwdata_setup", setup_pwdata, 32'hAB00_0000);
    check("t2_pwdata_access", acc_pwdata, 32'hAB00_0000);
    check("t2_paddr_access", {20'd0, acc_paddr}, 32'h003);

    // 3: read with 5 ACCESS wait cycles
    cfg_wait = 5; cfg_rdata = 32'h1234_5678; pc0 = pen_cycles;
    ahb_xfer(32'h4000_0100, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'd0, waits, lresp, fresp, rd);
    $display("T3 slow read waits=%0d penable_cycles=%0d", waits, pen_cycles - pc0);
    check("t3_penable_cycles", pen_cycles - pc0, 6);
    check("t3_waits", waits, 8);
    check("t3_hrdata", rd, 32'h1234_5678);
    cfg_wait = 0;

    // 4: write with PSLVERR
    cfg_err = 1'b1;
    ahb_xfer(32'h4000_0020, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h5555_AAAA, waits, lresp, fresp, rd);
    $display("T4 slverr waits=%0d last_wait_resp=%0d final_resp=%0d", waits, lresp, fresp);
    check("t4_waits", waits, 5);
    check("t4_err1_hresp", {31'd0, lresp}, 32'd1);
    check("t4_err2_hresp", {31'd0, fresp}, 32'd1);
    cfg_err = 1'b0;
    @(negedge clk);
    check("t4_idle_okay", {30'd0, hreadyout, hresp}, 32'b10);
    @(posedge clk); #1;

    // 5: decode errors and zero-wait idle/busy
    xf0 = apb_xfers; ps0 = psel_cycles;
    ahb_xfer(32'h4000_0002, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'd0, waits, lresp, fresp, rd);
    $display("T5 misaligned waits=%0d resp=%0d/%0d", waits, lresp, fresp);
    check("t5_mis_waits", waits, 1);
    check("t5_mis_resp", {30'd0, lresp, fresp}, 32'b11);
    ahb_xfer(32'h4000_0000, 1'b1, 3'd3, HTRANS_SEQ, 32'hFFFF_FFFF, waits, lresp, fresp, rd);
    $display("T5 hsize3 waits=%0d resp=%0d/%0d", waits, lresp, fresp);
    check("t5_size_waits", waits, 1);
    check("t5_size_resp", {30'd0, lresp, fresp}, 32'b11);
    ahb_xfer(32'h4000_0004, 1'b0, HSIZE_WORD, HTRANS_IDLE, 32'd0, waits, lresp, fresp, rd);
    $display("T5 idle waits=%0d resp=%0d", waits, fresp);
    check("t5_idle", {waits[30:0], fresp}, 32'd0);
    ahb_xfer(32'h4000_0004, 1'b1, HSIZE_WORD, HTRANS_BUSY, 32'd0, waits, lresp, fresp, rd);
    $display("T5 busy waits=%0d resp=%0d", waits, fresp);
    check("t5_busy", {waits[30:0], fresp}, 32'd0);
    check("t5_no_apb_xfer", apb_xfers - xf0, 0);
    check("t5_no_psel", psel_cycles - ps0, 0);

    // 6: reset in the middle of ACCESS
    cfg_wait = 10;
    hsel = 1'b1; haddr = 32'h4000_0040; htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_IDLE;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (penable) break;
    end
    check("t6_access_reached", {31'd0, penable}, 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("T6 reset mid-access psel=%0d penable=%0d hreadyout=%0d", psel, penable, hreadyout);
    check("t6_psel_drop", {31'd0, psel}, 32'd0);
    check("t6_penable_drop", {31'd0, penable}, 32'd0);
    check("t6_hreadyout", {31'd0, hreadyout}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; cfg_wait = 0; cfg_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    ahb_xfer(32'h4000_0044, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'd0, waits, lresp, fresp, rd);
    $display("T6 read after reset waits=%0d hrdata=%h", waits, rd);
    check("t6_read_waits", waits, 3);
    check("t6_read_data", rd, 32'hCAFE_F00D);

    // Randomized aligned traffic against the model
    for (int n = 0; n < 24; n++) begin
      w = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 2));
      a = $urandom & ~((32'd1 << sz) - 32'd1);
      wd = $urandom;
      extra = $urandom_range(0, 2);
      cfg_wait = extra;
      cfg_rdata = $urandom;
      xf0 = apb_xfers;
      ahb_xfer(a, w, sz, HTRANS_NONSEQ, wd, waits, lresp, fresp, rd);
      $display("R%0d %s size=%0d addr=%h waits=%0d paddr=%h pstrb=%b pwdata=%h hrdata=%h",
               n, w ? "W" : "R", sz, a, waits, acc_paddr, setup_pstrb, acc_pwdata, rd);
      check("rnd_waits", waits, (w ? 4 : 3) + extra);
      check("rnd_resp", {31'd0, fresp}, 32'd0);
      check("rnd_one_access", apb_xfers - xf0, 1);
      check("rnd_paddr_setup", {20'd0, setup_paddr}, {20'd0, a[11:0]});
      check("rnd_paddr_access", {20'd0, acc_paddr}, {20'd0, a[11:0]});
      check("rnd_pwrite", {31'd0, setup_pwrite}, {31'd0, w});
      check("rnd_pstrb_setup", {28'd0, setup_pstrb}, {28'd0, model_strb(w, sz, a)});
      check("rnd_pstrb_access", {28'd0, acc_pstrb}, {28'd0, model_strb(w, sz, a)});
      if (w) begin
        check("rnd_pwdata_setup", setup_pwdata, wd);
        check("rnd_pwdata_access", acc_pwdata, wd);
      end else begin
        check("rnd_hrdata", rd, cfg_rdata);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
